parity_gen_check: RTL

//   Parametrised even/odd parity generator and checker for a WIDTH-bit data path.

---
 rtl/parity_gen_check.sv | 97 +++++++++
 1 files changed

// File: rtl/parity_gen_check.sv
// Even/odd parity generator (registered valid/ready stage) and parity checker
// with a saturating error counter and sticky error flag.
module parity_gen_check #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 odd_sel,
  input  logic                 gen_in_valid,
  output logic                 gen_in_ready,
  input  logic [WIDTH-1:0]     gen_in_data,
  output logic                 gen_out_valid,
  input  logic                 gen_out_ready,
  output logic [WIDTH:0]       gen_out_word,
  input  logic                 chk_in_valid,
  input  logic [WIDTH:0]       chk_in_word,
  output logic                 chk_out_valid,
  output logic [WIDTH-1:0]     chk_out_data,
  output logic                 chk_out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 err_sticky,
  input  logic                 clr_err
);

  localparam logic [ERR_CNT_W-1:0] CNT_ZERO = {ERR_CNT_W{1'b0}};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE  = ERR_CNT_W'(1);

  function automatic logic gen_parity(input logic [WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic logic word_has_error(input logic [WIDTH:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

  logic                 accept_s;
  logic                 word_err_s;
  logic [ERR_CNT_W-1:0] cnt_base_s;
  logic [ERR_CNT_W-1:0] cnt_next_s;
  logic                 sticky_next_s;

  // The output slot can take a new word when empty or when it drains this cycle.
  assign gen_in_ready = !gen_out_valid || gen_out_ready;
  assign accept_s     = gen_in_valid && gen_in_ready;

  // Generator output register: load on accept, empty on a transfer, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_out_valid <= 1'b0;
      gen_out_word  <= {(WIDTH+1){1'b0}};
    end else if (accept_s) begin
      gen_out_valid <= 1'b1;
      gen_out_word  <= {gen_parity(gen_in_data, odd_sel), gen_in_data};
    end else if (gen_out_ready) begin
      gen_out_valid <= 1'b0;
    end else begin
      gen_out_valid <= gen_out_valid;
    end
  end

  // Clear is applied before the incoming error so clear+error yields a count of one.
  always_comb begin
    word_err_s    = chk_in_valid && word_has_error(chk_in_word, odd_sel);
    cnt_base_s    = clr_err ? CNT_ZERO : err_count;
    cnt_next_s    = cnt_base_s;
    sticky_next_s = (err_sticky && !clr_err) || word_err_s;
    if (word_err_s && (cnt_base_s != CNT_MAX)) begin
      cnt_next_s = cnt_base_s + CNT_ONE;
    end else begin
      cnt_next_s = cnt_base_s;
    end
  end

  // Checker result registers; data field holds its last value between words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_out_valid <= 1'b0;
      chk_out_data  <= {WIDTH{1'b0}};
      chk_out_err   <= 1'b0;
      err_count     <= CNT_ZERO;
      err_sticky    <= 1'b0;
    end else begin
      chk_out_valid <= chk_in_valid;
      chk_out_err   <= word_err_s;
      err_count     <= cnt_next_s;
      err_sticky    <= sticky_next_s;
      if (chk_in_valid) begin
        chk_out_data <= chk_in_word[WIDTH-1:0];
      end else begin
        chk_out_data <= chk_out_data;
      end
    end
  end

endmodule
